// File: rtl/lsq_ret_bundle_q.sv
// lsq_ret_bundle_q: retire-bundle queue feeding the LSQ retire decision stage.
// Buffers up to DEPTH six-lane load/store bundles and presents the oldest live
// bundle on dataB_*. It ORs late load conflicts into buffered bundles and drops
// the bundles of a thread that takes an exception.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   wr_*              bundle push (wr_en strobes one bundle)
//   cf_*              late load-conflict update by retire tag
//   dataB_*           head bundle; dataB_enOut pops it
//   except*           per-thread flush
//   full, count       occupancy (count includes killed entries)
//   overflow          sticky: a push arrived while full
`ifndef LSQSHARE_WIDTH
`define LSQSHARE_WIDTH 32
`endif
module lsq_ret_bundle_q #(
    parameter int DEPTH     = 8,
    parameter int SHR_WIDTH = `LSQSHARE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [5:0]              wr_II,
    input  logic                    wr_thread,
    input  logic [5:0]              wr_ret_mask,
    input  logic [5:0]              wr_excpt,
    input  logic [5:0]              wr_ld_confl,
    input  logic [5:0]              wr_wait_confl,
    input  logic [23:0]             wr_exbits,
    input  logic [23:0]             wr_lane_II,
    input  logic [SHR_WIDTH-1:0]    wr_shr,
    input  logic                    cf_en,
    input  logic [5:0]              cf_II,
    input  logic [5:0]              cf_mask,
    output logic                    dataB_ready,
    output logic [5:0]              dataB_II,
    output logic                    dataB_thread,
    output logic [5:0]              dataB_ret_mask,
    output logic [5:0]              dataB_excpt,
    output logic [5:0]              dataB_ld_confl,
    output logic [5:0]              dataB_wait_confl,
    output logic [23:0]             dataB_exbits,
    output logic [3:0]              dataB_II0,
    output logic [3:0]              dataB_II1,
    output logic [3:0]              dataB_II2,
    output logic [3:0]              dataB_II3,
    output logic [3:0]              dataB_II4,
    output logic [3:0]              dataB_II5,
    output logic [SHR_WIDTH-1:0]    dataB_data_shr,
    input  logic                    dataB_enOut,
    input  logic                    except,
    input  logic                    except_thread,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [SHR_WIDTH-1:0] shr;
        logic [23:0]          lane;
        logic [23:0]          exb;
        logic [5:0]           wt;
        logic [5:0]           ld;
        logic [5:0]           exc;
        logic [5:0]           ret;
        logic                 thr;
        logic [5:0]           ii;
    } ent_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    logic [DEPTH-1:0] val_q, val_d;
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    ent_t             head, wr_ent;
    logic             flush_drop, push, pop, skip, wr_hit;

    assign head        = ent_q[rd_q];
    assign full        = cnt_q == CW'(DEPTH);
    assign count       = cnt_q;
    assign overflow    = ovf_q;
    assign dataB_ready = (cnt_q != '0) && val_q[rd_q];
    // A push belonging to the thread being flushed is simply discarded.
    assign flush_drop  = except && (wr_thread == except_thread);
    assign push        = wr_en && !full && !flush_drop;
    assign pop         = dataB_enOut && dataB_ready;
    // Killed entries at the head are retired one per cycle without being shown.
    assign skip        = (cnt_q != '0) && !val_q[rd_q];
    assign wr_hit      = cf_en && (wr_II == cf_II);

    assign dataB_II         = head.ii;
    assign dataB_thread     = head.thr;
    assign dataB_ret_mask   = head.ret;
    assign dataB_excpt      = head.exc;
    assign dataB_ld_confl   = head.ld;
    assign dataB_wait_confl = head.wt;
    assign dataB_exbits     = head.exb;
    assign dataB_II0        = head.lane[3:0];
    assign dataB_II1        = head.lane[7:4];
    assign dataB_II2        = head.lane[11:8];
    assign dataB_II3        = head.lane[15:12];
    assign dataB_II4        = head.lane[19:16];
    assign dataB_II5        = head.lane[23:20];
    assign dataB_data_shr   = head.shr;

    always_comb begin
        wr_ent.shr  = wr_shr;
        wr_ent.lane = wr_lane_II;
        wr_ent.exb  = wr_exbits;
        wr_ent.wt   = wr_hit ? (wr_wait_confl & ~cf_mask) : wr_wait_confl;
        wr_ent.ld   = wr_hit ? (wr_ld_confl | cf_mask) : wr_ld_confl;
        wr_ent.exc  = wr_excpt;
        wr_ent.ret  = wr_ret_mask;
        wr_ent.thr  = wr_thread;
        wr_ent.ii   = wr_II;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            val_d[i] = val_q[i];
            if (cf_en && val_q[i] && (ent_q[i].ii == cf_II)) begin
                ent_d[i].ld = ent_q[i].ld | cf_mask;
                ent_d[i].wt = ent_q[i].wt & ~cf_mask;
            end
            if ((pop && (rd_q == AW'(i))) || (except && (ent_q[i].thr == except_thread)))
                val_d[i] = 1'b0;
            // The write slot is always free when not full, since count covers killed entries.
            if (push && (wr_q == AW'(i))) begin
                ent_d[i] = wr_ent;
                val_d[i] = 1'b1;
            end
        end
        rd_d  = rd_q + AW'(pop || skip);
        wr_d  = wr_q + AW'(push);
        cnt_d = cnt_q + CW'(push) - CW'(pop || skip);
        ovf_d = ovf_q | (wr_en && full && !flush_drop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            val_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= ent_d[i];
            val_q <= val_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_lsq_ret_bundle_q.sv
// tb_lsq_ret_bundle_q: directed vectors, corner sequences and a random run against a queue model.
module tb_lsq_ret_bundle_q;
    localparam int DEPTH = 8;
    localparam int SW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr_en, wr_thread, cf_en, dataB_enOut, except, except_thread;
    logic [5:0] wr_II, wr_ret_mask, wr_excpt, wr_ld_confl, wr_wait_confl, cf_II, cf_mask;
    logic [23:0] wr_exbits, wr_lane_II;
    logic [SW-1:0] wr_shr;
    logic dataB_ready, dataB_thread, full, overflow;
    logic [5:0] dataB_II, dataB_ret_mask, dataB_excpt, dataB_ld_confl, dataB_wait_confl;
    logic [23:0] dataB_exbits;
    logic [3:0] dataB_II0, dataB_II1, dataB_II2, dataB_II3, dataB_II4, dataB_II5;
    logic [SW-1:0] dataB_data_shr;
    logic [3:0] count;

    always #5 clk = ~clk;

    lsq_ret_bundle_q #(.DEPTH(DEPTH), .SHR_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_II(wr_II), .wr_thread(wr_thread), .wr_ret_mask(wr_ret_mask),
        .wr_excpt(wr_excpt), .wr_ld_confl(wr_ld_confl), .wr_wait_confl(wr_wait_confl),
        .wr_exbits(wr_exbits), .wr_lane_II(wr_lane_II), .wr_shr(wr_shr),
        .cf_en(cf_en), .cf_II(cf_II), .cf_mask(cf_mask),
        .dataB_ready(dataB_ready), .dataB_II(dataB_II), .dataB_thread(dataB_thread),
        .dataB_ret_mask(dataB_ret_mask), .dataB_excpt(dataB_excpt),
        .dataB_ld_confl(dataB_ld_confl), .dataB_wait_confl(dataB_wait_confl),
        .dataB_exbits(dataB_exbits),
        .dataB_II0(dataB_II0), .dataB_II1(dataB_II1), .dataB_II2(dataB_II2),
        .dataB_II3(dataB_II3), .dataB_II4(dataB_II4), .dataB_II5(dataB_II5),
        .dataB_data_shr(dataB_data_shr), .dataB_enOut(dataB_enOut),
        .except(except), .except_thread(except_thread),
        .full(full), .count(count), .overflow(overflow)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_II = '0; wr_thread = 1'b0; wr_ret_mask = '0; wr_excpt = '0;
        wr_ld_confl = '0; wr_wait_confl = 6'h3F; wr_exbits = '0; wr_lane_II = '0; wr_shr = '0;
        cf_en = 1'b0; cf_II = '0; cf_mask = '0; dataB_enOut = 1'b0; except = 1'b0; except_thread = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push_b(input logic [5:0] ii, input logic thr);
        wr_en = 1'b1; wr_II = ii; wr_thread = thr;
        tick();
    endtask

    task automatic pop_b();
        dataB_enOut = 1'b1;
        tick();
    endtask

    typedef struct {
        logic wen; logic [5:0] wii; logic cf; logic [5:0] cii; logic [5:0] cm; logic pop;
        logic [3:0] ecnt; logic erdy; logic [5:0] eii; logic [5:0] eld; logic [5:0] ewt;
    } vec_t;
    vec_t vt [8];

    typedef struct {
        logic [5:0] ii; logic thr; logic [5:0] ret, exc, ld, wt;
        logic [23:0] exb, lane; logic [SW-1:0] shr; logic live;
    } bund_t;
    bund_t mq[$];
    logic m_ovf;

    task automatic model_check();
        logic rdy;
        rdy = (mq.size() > 0) && mq[0].live;
        chk("m_count", 64'(count), 64'(mq.size()));
        chk("m_full", 64'(full), 64'(mq.size() == DEPTH));
        chk("m_overflow", 64'(overflow), 64'(m_ovf));
        chk("m_ready", 64'(dataB_ready), 64'(rdy));
        if (rdy && dataB_ready) begin
            chk("m_II", 64'(dataB_II), 64'(mq[0].ii));
            chk("m_thread", 64'(dataB_thread), 64'(mq[0].thr));
            chk("m_ret", 64'(dataB_ret_mask), 64'(mq[0].ret));
            chk("m_excpt", 64'(dataB_excpt), 64'(mq[0].exc));
            chk("m_ld", 64'(dataB_ld_confl), 64'(mq[0].ld));
            chk("m_wait", 64'(dataB_wait_confl), 64'(mq[0].wt));
            chk("m_exbits", 64'(dataB_exbits), 64'(mq[0].exb));
            chk("m_lanes", 64'({dataB_II5, dataB_II4, dataB_II3, dataB_II2, dataB_II1, dataB_II0}), 64'(mq[0].lane));
            chk("m_shr", 64'(dataB_data_shr), 64'(mq[0].shr));
        end
    endtask

    // Queue model: conflict and flush act on buffered bundles, then the head leaves, then the new bundle joins.
    task automatic model_step();
        bund_t b;
        logic rdy, fdrop, fullm, leave;
        rdy = (mq.size() > 0) && mq[0].live;
        fullm = mq.size() == DEPTH;
        fdrop = except && (wr_thread == except_thread);
        if (wr_en && fullm && !fdrop) m_ovf = 1'b1;
        leave = (dataB_enOut && rdy) || ((mq.size() > 0) && !mq[0].live);
        foreach (mq[k]) begin
            if (cf_en && mq[k].live && mq[k].ii == cf_II) begin
                mq[k].ld = mq[k].ld | cf_mask;
                mq[k].wt = mq[k].wt & ~cf_mask;
            end
            if (except && mq[k].thr == except_thread) mq[k].live = 1'b0;
        end
        if (leave) void'(mq.pop_front());
        if (wr_en && !fullm && !fdrop) begin
            b.ii = wr_II; b.thr = wr_thread; b.ret = wr_ret_mask; b.exc = wr_excpt;
            b.ld = wr_ld_confl; b.wt = wr_wait_confl; b.exb = wr_exbits; b.lane = wr_lane_II;
            b.shr = wr_shr; b.live = 1'b1;
            if (cf_en && wr_II == cf_II) begin
                b.ld = b.ld | cf_mask;
                b.wt = b.wt & ~cf_mask;
            end
            mq.push_back(b);
        end
    endtask

    initial begin
        idle();
        #12;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ready", 64'(dataB_ready), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_II", 64'(dataB_II), 64'(0));
        rst = 1'b1;
        tick();

        vt[0] = '{1'b1, 6'd3, 1'b0, 6'd0, 6'h00, 1'b0, 4'd1, 1'b1, 6'd3, 6'h00, 6'h3F};
        vt[1] = '{1'b0, 6'd0, 1'b1, 6'd3, 6'h05, 1'b0, 4'd1, 1'b1, 6'd3, 6'h05, 6'h3A};
        vt[2] = '{1'b0, 6'd0, 1'b0, 6'd0, 6'h00, 1'b1, 4'd0, 1'b0, 6'd0, 6'h00, 6'h00};
        vt[3] = '{1'b1, 6'd5, 1'b1, 6'd5, 6'h20, 1'b0, 4'd1, 1'b1, 6'd5, 6'h20, 6'h1F};
        vt[4] = '{1'b1, 6'd6, 1'b0, 6'd0, 6'h00, 1'b1, 4'd1, 1'b1, 6'd6, 6'h00, 6'h3F};
        vt[5] = '{1'b0, 6'd0, 1'b1, 6'd9, 6'h3F, 1'b0, 4'd1, 1'b1, 6'd6, 6'h00, 6'h3F};
        vt[6] = '{1'b0, 6'd0, 1'b0, 6'd0, 6'h00, 1'b1, 4'd0, 1'b0, 6'd0, 6'h00, 6'h00};
        vt[7] = '{1'b0, 6'd0, 1'b0, 6'd0, 6'h00, 1'b1, 4'd0, 1'b0, 6'd0, 6'h00, 6'h00};
        for (int v = 0; v < 8; v++) begin
            wr_en = vt[v].wen; wr_II = vt[v].wii; cf_en = vt[v].cf; cf_II = vt[v].cii;
            cf_mask = vt[v].cm; dataB_enOut = vt[v].pop;
            tick();
            chk($sformatf("vec%0d_count", v), 64'(count), 64'(vt[v].ecnt));
            chk($sformatf("vec%0d_ready", v), 64'(dataB_ready), 64'(vt[v].erdy));
            if (vt[v].erdy) begin
                chk($sformatf("vec%0d_II", v), 64'(dataB_II), 64'(vt[v].eii));
                chk($sformatf("vec%0d_ld", v), 64'(dataB_ld_confl), 64'(vt[v].eld));
                chk($sformatf("vec%0d_wait", v), 64'(dataB_wait_confl), 64'(vt[v].ewt));
            end
        end

        for (int k = 1; k <= 8; k++) push_b(6'(k), 1'b0);
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_count", 64'(count), 64'(8));
        push_b(6'd9, 1'b0);
        chk("ovf_set", 64'(overflow), 64'(1));
        chk("ovf_count", 64'(count), 64'(8));
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain_II%0d", k), 64'(dataB_II), 64'(k));
            pop_b();
        end
        chk("drain_ready", 64'(dataB_ready), 64'(0));
        chk("drain_full", 64'(full), 64'(0));

        push_b(6'd10, 1'b0); push_b(6'd11, 1'b1); push_b(6'd12, 1'b0); push_b(6'd13, 1'b1);
        except = 1'b1; except_thread = 1'b0;
        tick();
        chk("flush_ready", 64'(dataB_ready), 64'(0));
        chk("flush_count", 64'(count), 64'(4));
        tick();
        chk("skip1_count", 64'(count), 64'(3));
        chk("skip1_ready", 64'(dataB_ready), 64'(1));
        chk("skip1_II", 64'(dataB_II), 64'(11));
        pop_b();
        chk("fpop_count", 64'(count), 64'(2));
        chk("fpop_ready", 64'(dataB_ready), 64'(0));
        tick();
        chk("skip2_II", 64'(dataB_II), 64'(13));
        chk("skip2_count", 64'(count), 64'(1));
        pop_b();
        chk("flush_empty", 64'(count), 64'(0));

        push_b(6'd20, 1'b0); push_b(6'd21, 1'b0); push_b(6'd22, 1'b0);
        wr_en = 1'b1; wr_II = 6'd23; dataB_enOut = 1'b1;
        tick();
        chk("pp_count", 64'(count), 64'(3));
        chk("pp_II", 64'(dataB_II), 64'(21));
        pop_b(); pop_b();
        chk("pp_new_II", 64'(dataB_II), 64'(23));
        pop_b();
        chk("pp_empty", 64'(dataB_ready), 64'(0));

        push_b(6'd30, 1'b0);
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; wr_II = 6'(31 + k); dataB_enOut = 1'b1;
            tick();
            chk($sformatf("wrap%0d_count", k), 64'(count), 64'(1));
            chk($sformatf("wrap%0d_II", k), 64'(dataB_II), 64'(31 + k));
        end

        for (int k = 0; k < 4; k++) push_b(6'(60 + k), 1'b1);
        chk("pre_rst_count", 64'(count), 64'(5));
        rst = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_ready", 64'(dataB_ready), 64'(0));
        chk("arst_overflow", 64'(overflow), 64'(0));
        #2;
        rst = 1'b1;
        tick();

        m_ovf = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int pp;
            pp = ((c / 200) % 2 == 1) ? 80 : 35;
            wr_en = $urandom_range(0, 99) < pp;
            wr_II = 6'($urandom_range(0, 7));
            wr_thread = 1'($urandom);
            wr_ret_mask = 6'($urandom); wr_excpt = 6'($urandom);
            wr_ld_confl = 6'($urandom); wr_wait_confl = 6'($urandom);
            wr_exbits = 24'($urandom); wr_lane_II = 24'($urandom); wr_shr = SW'($urandom);
            cf_en = $urandom_range(0, 99) < 25;
            cf_II = 6'($urandom_range(0, 7)); cf_mask = 6'($urandom);
            dataB_enOut = $urandom_range(0, 99) < (115 - pp);
            except = $urandom_range(0, 99) < 4;
            except_thread = 1'($urandom);
            model_check();
            model_step();
            tick();
        end
        model_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
